serial_add_seq: RTL and testbench

Bit-serial addition sequencer that time-shares a single external 1-bit full-adder slice to add two WIDTH-bit operands, LSB first, one bit per clock. Accepts a start request, drives the slice's three operand inputs each cycle, captures its sum/carry outputs, and presents the registered WIDTH-bit result with carry-out and signed overflow. Sits between the board I/O / control logic and the full-adder datapath. The top level inserts any pin-polarity inversion; all slice signals here are active-high.

---
 rtl/serial_add_seq.sv | 111 +++++++++++
 tb/tb_serial_add_seq.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_seq.sv
// serial_add_seq
// Bit-serial adder sequencer. Time-shares one external combinational 1-bit
// full-adder slice to add two WIDTH-bit operands LSB first, one bit per clock.
// The registered result {cout, sum} = a + b + cin; ovf is the two's-complement
// overflow flag (carry into MSB xor carry out of MSB).
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   start         request, sampled only in IDLE or DONE
//   a, b, cin     operands, sampled on the accepting edge only
//   fa_op         to slice: {carry_in, b_bit, a_bit}; zero outside RUN
//   fa_res        from slice (combinational): {carry_out, sum_bit}
//   busy          high while a bit-serial addition is running
//   done          one-cycle pulse, result registers just updated
//   sum/cout/ovf  registered result, updated only when an addition completes
//   dbg_state     current FSM state (IDLE=0, RUN=1, DONE=2)
//
// Handshake: start is a level request; the sequencer accepts it on any edge
// where it is idle or finishing (DONE), and ignores it while busy. There is no
// back-pressure and no queuing; done is a single-cycle qualifier for the result.
module serial_add_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [2:0]       fa_op,
  input  logic [1:0]       fa_res,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] work_sh;
  logic             carry_reg;
  logic [CW-1:0]    cnt;

  // Outputs decode directly from registered state, so they are glitch-free
  // with respect to the inputs.
  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign fa_op     = (state == RUN) ? {carry_reg, b_sh[0], a_sh[0]} : 3'b000;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      work_sh   <= '0;
      carry_reg <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= RUN;
            a_sh      <= a;
            b_sh      <= b;
            carry_reg <= cin;
            cnt       <= '0;
            work_sh   <= '0;
          end else begin
            state <= IDLE;
          end
        end

        RUN: begin
          // Sum bits enter at the MSB and walk right, so after WIDTH shifts
          // bit 0 of the operands has landed in bit 0 of the result.
          work_sh   <= {fa_res[0], work_sh[WIDTH-1:1]};
          a_sh      <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh      <= {1'b0, b_sh[WIDTH-1:1]};
          carry_reg <= fa_res[1];
          cnt       <= cnt + CW'(1);
          if (cnt == LAST) begin
            state <= DONE;
            sum   <= {fa_res[0], work_sh[WIDTH-1:1]};
            cout  <= fa_res[1];
            // During the MSB cycle carry_reg holds the carry into the MSB.
            ovf   <= fa_res[1] ^ carry_reg;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_seq.sv
// tb_serial_add_seq
// Directed plus randomized bench for serial_add_seq (WIDTH=8). The external
// full-adder slice is modelled combinationally. Expected results come from
// whole-word arithmetic (a + b + cin) and per-bit expected slice operands are
// derived from partial sums of the operands.
module tb_serial_add_seq;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic [2:0]   fa_op;
  logic [1:0]   fa_res;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic [1:0]   dbg_state;

  serial_add_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .fa_op     (fa_op),
    .fa_res    (fa_res),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .dbg_state (dbg_state)
  );

  // External 1-bit full-adder slice: {carry_out, sum_bit} = sum of three bits.
  assign fa_res = {1'b0, fa_op[0]} + {1'b0, fa_op[1]} + {1'b0, fa_op[2]};

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [W+1:0] exp_q[$];   // {ovf, cout, sum}
  logic [W-1:0] held_sum;
  logic         held_cout;
  logic         held_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: whole-word addition, two's-complement overflow rule.
  function automatic logic [W+1:0] ref_result(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                              input logic rc);
    logic [W:0] t;
    logic       v;
    t = {1'b0, ra} + {1'b0, rb} + (W+1)'(rc);
    v = (ra[W-1] == rb[W-1]) && (t[W-1] != ra[W-1]);
    return {v, t[W], t[W-1:0]};
  endfunction

  // Expected slice operands for bit i: carry into bit i from the low i bits.
  function automatic logic [2:0] ref_op(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                        input logic rc, input int i);
    longint unsigned m;
    longint unsigned t;
    m = (64'd1 << i) - 64'd1;
    t = (64'(ra) & m) + (64'(rb) & m) + 64'(rc);
    return {t[i], rb[i], ra[i]};
  endfunction

  // ---------------- driver tasks ----------------
  // Called away from the clock edge with the DUT in IDLE or DONE. Returns
  // #1 after the edge that enters DONE. keep: hold start high for a
  // back-to-back follow-on; pulse_at: RUN cycle index to pulse start (-1 none);
  // scramble: change a/b/cin every RUN cycle.
  task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b, input logic op_cin,
                        input bit keep, input int pulse_at, input bit scramble);
    logic [W+1:0] e;
    start = 1'b1;
    a     = op_a;
    b     = op_b;
    cin   = op_cin;
    exp_q.push_back(ref_result(op_a, op_b, op_cin));
    @(posedge clk); #1;
    for (int i = 0; i < W; i++) begin
      start = keep || (i == pulse_at);
      if (scramble) begin
        a   = W'($urandom);
        b   = W'($urandom);
        cin = 1'($urandom);
      end
      chk("busy_in_run", 32'(busy), 32'd1);
      chk("done_in_run", 32'(done), 32'd0);
      chk($sformatf("fa_op_bit%0d", i), 32'(fa_op), 32'(ref_op(op_a, op_b, op_cin, i)));
      chk("sum_hold_run", 32'({ovf, cout, sum}), 32'({held_ovf, held_cout, held_sum}));
      @(posedge clk); #1;
    end
    start = keep;
    e = exp_q.pop_front();
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_in_done", 32'(busy), 32'd0);
    chk("fa_op_done", 32'(fa_op), 32'd0);
    chk("sum", 32'(sum), 32'(e[W-1:0]));
    chk("cout", 32'(cout), 32'(e[W]));
    chk("ovf", 32'(ovf), 32'(e[W+1]));
    held_sum  = e[W-1:0];
    held_cout = e[W];
    held_ovf  = e[W+1];
  endtask

  // One cycle after a DONE with start low: back in IDLE, result held.
  task automatic idle_check();
    @(posedge clk); #1;
    chk("done_idle", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("fa_op_idle", 32'(fa_op), 32'd0);
    chk("sum_hold_idle", 32'({ovf, cout, sum}), 32'({held_ovf, held_cout, held_sum}));
  endtask

  // ---------------- stimulus ----------------
  logic [W-1:0] tab_a[4]   = '{8'hFF, 8'hFF, 8'h80, 8'h7F};
  logic [W-1:0] tab_b[4]   = '{8'h01, 8'h00, 8'h80, 8'h00};
  logic         tab_c[4]   = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [W+1:0] tab_exp[4] = '{{1'b0, 1'b1, 8'h00}, {1'b0, 1'b1, 8'h00},
                               {1'b1, 1'b1, 8'h00}, {1'b1, 1'b0, 8'h80}};

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    held_sum = '0; held_cout = 1'b0; held_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'({ovf, cout, sum}), 32'd0);
    chk("rst_fa_op", 32'(fa_op), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed: 0x5A + 0x3C
    run_op(8'h5A, 8'h3C, 1'b0, 1'b0, -1, 1'b0);
    chk("tp_5a3c", 32'({ovf, cout, sum}), 32'({1'b1, 1'b0, 8'h96}));
    idle_check();

    // Directed carry / overflow corners
    for (int k = 0; k < 4; k++) begin
      run_op(tab_a[k], tab_b[k], tab_c[k], 1'b0, -1, 1'b0);
      chk($sformatf("tp_corner%0d", k), 32'({ovf, cout, sum}), 32'(tab_exp[k]));
      idle_check();
    end

    // Back-to-back with start held high; operands scrambled while busy
    for (int k = 0; k < 3; k++) begin
      run_op(8'h01, 8'h02, 1'b0, (k < 2), -1, 1'b1);
      chk($sformatf("b2b_sum%0d", k), 32'(sum), 32'h03);
    end
    idle_check();

    // start pulsed in RUN cycle 3 is ignored
    run_op(8'h33, 8'h44, 1'b1, 1'b0, 3, 1'b1);
    idle_check();
    chk("no_restart", 32'(busy), 32'd0);

    // Reset abort at the 4th RUN cycle
    start = 1'b1; a = 8'hC3; b = 8'h5F; cin = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("abort_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", 32'({ovf, cout, sum}), 32'd0);
    chk("abort_fa_op", 32'(fa_op), 32'd0);
    held_sum = '0; held_cout = 1'b0; held_ovf = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      chk("abort_no_done", 32'(done), 32'd0);
    end

    // rst wins over start on the same edge
    start = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; rst = 1'b0;
    chk("rst_over_start", 32'(busy), 32'd0);

    // Next start after abort runs normally
    run_op(8'hC3, 8'h5F, 1'b1, 1'b0, -1, 1'b0);
    idle_check();

    // Randomized operations
    for (int k = 0; k < 20; k++) begin
      bit keep;
      int pa;
      keep = (k < 19) && ($urandom_range(0, 1) == 1);
      pa   = $urandom_range(0, 3) == 0 ? $urandom_range(0, W-1) : -1;
      run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), keep, pa,
             ($urandom_range(0, 1) == 1));
      if (!keep) idle_check();
    end

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
